// File: rtl/uart_link_core.sv
// Full-duplex UART with TX/RX FIFOs, framing and overrun detection.
// Optional even parity when UART_PARITY_EN is defined.
module uart_link_core #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 1152000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_tx_busy,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_overrun,
  output logic                 o_rx_parity_err,
  input  logic                 i_uart_rxd,
  output logic                 o_uart_txd
);
  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
  localparam logic [3:0]    C_LAST = 4'(DATA_BITS - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} st_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;
`endif

  logic [DATA_BITS-1:0] r_txm [FIFO_DEPTH];
  logic [DATA_BITS-1:0] r_rxm [FIFO_DEPTH];
  logic [AW:0]          r_txw, r_txr, r_rxw, r_rxr;
  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

  st_t                  r_tx_st, w_tx_nxt, r_rx_st, w_rx_nxt;
  logic [CW-1:0]        r_tx_cnt, r_rx_cnt;
  logic [3:0]           r_tx_bit, r_rx_bit;
  logic [DATA_BITS-1:0] r_tx_sh, r_rx_sh;
  logic w_tx_tick, w_rx_tick, w_txd;
  logic r_s1, r_s2, r_s3;
  logic w_rxs, w_rx_fall, w_rx_done, w_par_ok, w_good;
`ifdef UART_PARITY_EN
  logic r_tx_par, r_rx_pbit;
`endif

  assign w_tx_empty = (r_txw == r_txr);
  assign w_tx_full  = (r_txw[AW] != r_txr[AW]) &&
                      (r_txw[AW-1:0] == r_txr[AW-1:0]);
  assign w_rx_empty = (r_rxw == r_rxr);
  assign w_rx_full  = (r_rxw[AW] != r_rxr[AW]) &&
                      (r_rxw[AW-1:0] == r_rxr[AW-1:0]);
  assign w_tx_push  = i_tx_valid & ~w_tx_full;
  assign w_rx_pop   = i_rx_ready & ~w_rx_empty;

  assign o_tx_ready = ~w_tx_full;
  assign o_tx_busy  = ~w_tx_empty | (r_tx_st != S_IDLE);
  assign o_rx_valid = ~w_rx_empty;
  assign o_rx_data  = w_rx_empty ? '0 : r_rxm[r_rxr[AW-1:0]];
  assign o_uart_txd = w_txd;

  // FIFO pointer registers for both directions
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_txw <= '0;
      r_txr <= '0;
      r_rxw <= '0;
      r_rxr <= '0;
    end else begin
      if (w_tx_push) r_txw <= r_txw + (AW+1)'(1);
      if (w_tx_pop)  r_txr <= r_txr + (AW+1)'(1);
      if (w_rx_push) r_rxw <= r_rxw + (AW+1)'(1);
      if (w_rx_pop)  r_rxr <= r_rxr + (AW+1)'(1);
    end
  end

  // FIFO storage, written at the tail pointer
  always_ff @(posedge i_clk) begin
    if (w_tx_push) r_txm[r_txw[AW-1:0]] <= i_tx_data;
    if (w_rx_push) r_rxm[r_rxw[AW-1:0]] <= r_rx_sh;
  end

  assign w_tx_tick = (r_tx_cnt == '0);

  // TX state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_tx_st <= S_IDLE;
    else       r_tx_st <= w_tx_nxt;
  end

  // TX next state; STOP chains straight into START when data is queued
  always_comb begin
    w_tx_nxt = r_tx_st;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      S_IDLE:  if (!w_tx_empty) begin
                 w_tx_pop = 1'b1;
                 w_tx_nxt = S_START;
               end
      S_START: if (w_tx_tick) w_tx_nxt = S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:  if (w_tx_tick && r_tx_bit == C_LAST) w_tx_nxt = S_PAR;
      S_PAR:   if (w_tx_tick) w_tx_nxt = S_STOP;
`else
      S_DATA:  if (w_tx_tick && r_tx_bit == C_LAST) w_tx_nxt = S_STOP;
`endif
      S_STOP:  if (w_tx_tick) begin
                 if (!w_tx_empty) begin
                   w_tx_pop = 1'b1;
                   w_tx_nxt = S_START;
                 end else begin
                   w_tx_nxt = S_IDLE;
                 end
               end
      default: w_tx_nxt = S_IDLE;
    endcase
  end

  // TX bit timer and shift register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_cnt <= C_FULL;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
`ifdef UART_PARITY_EN
      r_tx_par <= 1'b0;
`endif
    end else begin
      if (r_tx_st == S_IDLE || w_tx_tick) r_tx_cnt <= C_FULL;
      else                                r_tx_cnt <= r_tx_cnt - CW'(1);
      if (w_tx_pop) begin
        r_tx_sh  <= r_txm[r_txr[AW-1:0]];
        r_tx_bit <= '0;
`ifdef UART_PARITY_EN
        r_tx_par <= ^r_txm[r_txr[AW-1:0]];
`endif
      end else if (r_tx_st == S_DATA && w_tx_tick) begin
        r_tx_sh  <= r_tx_sh >> 1;
        r_tx_bit <= r_tx_bit + 4'd1;
      end
    end
  end

  // Line level decoded from TX state; idle and reset give a high line
  always_comb begin
    w_txd = 1'b1;
    case (r_tx_st)
      S_START: w_txd = 1'b0;
      S_DATA:  w_txd = r_tx_sh[0];
`ifdef UART_PARITY_EN
      S_PAR:   w_txd = r_tx_par;
`endif
      default: w_txd = 1'b1;
    endcase
  end

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_uart_rxd;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rxs     = r_s2;
  assign w_rx_fall = r_s3 & ~r_s2;
  assign w_rx_tick = (r_rx_cnt == '0);

  // RX state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rx_st <= S_IDLE;
    else       r_rx_st <= w_rx_nxt;
  end

  // RX next state; a high start resample is treated as a glitch
  always_comb begin
    w_rx_nxt  = r_rx_st;
    w_rx_done = 1'b0;
    case (r_rx_st)
      S_IDLE:  if (w_rx_fall) w_rx_nxt = S_START;
      S_START: if (w_rx_tick) w_rx_nxt = w_rxs ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:  if (w_rx_tick && r_rx_bit == C_LAST) w_rx_nxt = S_PAR;
      S_PAR:   if (w_rx_tick) w_rx_nxt = S_STOP;
`else
      S_DATA:  if (w_rx_tick && r_rx_bit == C_LAST) w_rx_nxt = S_STOP;
`endif
      S_STOP:  if (w_rx_tick) begin
                 w_rx_done = 1'b1;
                 w_rx_nxt  = S_IDLE;
               end
      default: w_rx_nxt = S_IDLE;
    endcase
  end

  // RX timer (half period to mid start bit) and sampling shift register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_cnt  <= C_HALF;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
`ifdef UART_PARITY_EN
      r_rx_pbit <= 1'b0;
`endif
    end else begin
      if (r_rx_st == S_IDLE) r_rx_cnt <= C_HALF;
      else if (w_rx_tick)    r_rx_cnt <= C_FULL;
      else                   r_rx_cnt <= r_rx_cnt - CW'(1);
      if (r_rx_st == S_START) begin
        r_rx_bit <= '0;
      end else if (r_rx_st == S_DATA && w_rx_tick) begin
        r_rx_sh  <= {w_rxs, r_rx_sh[DATA_BITS-1:1]};
        r_rx_bit <= r_rx_bit + 4'd1;
      end
`ifdef UART_PARITY_EN
      if (r_rx_st == S_PAR && w_rx_tick) r_rx_pbit <= w_rxs;
`endif
    end
  end

`ifdef UART_PARITY_EN
  assign w_par_ok = (r_rx_pbit == ^r_rx_sh);
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_good          = w_rx_done & w_rxs & w_par_ok;
  assign w_rx_push       = w_good & (~w_rx_full | w_rx_pop);
  assign o_rx_overrun    = w_good & w_rx_full & ~w_rx_pop;
  assign o_rx_frame_err  = w_rx_done & ~w_rxs;
  assign o_rx_parity_err = w_rx_done & ~w_par_ok;

endmodule
